store_buffer: RTL and testbench
===============================

# store_buffer

In-order store buffer that sits between the LSU and the D-cache store port. It allocates an entry per store at dispatch and is filled with address, data and op by the LSU at execute. It answers load store-to-load forwarding queries combinationally and drains committed stores to the D-cache in program order. It is the responder for the LSU's `sb_ex_*` fill interface and `sb_load_*` query interface.

## Interface
- `Cfg`, `config_pkg::EmptyCfg`: supplies XLEN and PLEN.
- `ROB_IDX_WIDTH`, 6: ROB tag width.
- `SB_DEPTH`, 16: entry count. Must be a power of two, ≥2.
- `SB_IDX_WIDTH`, `$clog2(SB_DEPTH)`: entry index width.

Ports (clock and reset first):
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset; **synchronous, active-low**.
- `flush_i`  in  1  pipeline flush; discards uncommitted entries.
- `rob_head_i`  in  ROB_IDX_WIDTH  current ROB head, used for age compare.
- `alloc_valid_i`  in  1  dispatch requests one entry.
- `alloc_ready_o`  out  1  buffer not full.
- `alloc_sb_id_o`  out  SB_IDX_WIDTH  id of the entry being allocated (tail).
- `ex_valid_i`  in  1  execute fill strobe.
- `ex_sb_id_i`  in  SB_IDX_WIDTH  entry to fill.
- `ex_addr_i`  in  PLEN  store address.
- `ex_data_i`  in  XLEN  store data (unshifted).
- `ex_op_i`  in  `decode_pkg::lsu_op_e`  store op (SB/SH/SW/SD).
- `ex_rob_idx_i`  in  ROB_IDX_WIDTH  store ROB tag.
- `ld_addr_i`  in  PLEN  forwarding query address.
- `ld_op_i`  in  `lsu_op_e`  load op.
- `ld_rob_idx_i`  in  ROB_IDX_WIDTH  load ROB tag.
- `ld_hit_o`  out  1  full forward available.
- `ld_block_o`  out  1  load must wait.
- `ld_data_o`  out  XLEN  forwarded raw store data.
- `commit_valid_i`  in  1  ROB retires the oldest uncommitted store.
- `st_req_valid_o`  out  1  drain request.
- `st_req_ready_i`  in  1  D-cache accepts.
- `st_req_addr_o`  out  PLEN  drain address.
- `st_req_data_o`  out  XLEN  drain data.
- `st_req_op_o`  out  `lsu_op_e`  drain op.
- `empty_o`  out  1  no valid entries, used for fence/drain wait.

## Operation
- **Circular FIFO.** Three pointers `head`, `commit`, `tail`, each SB_IDX_WIDTH+1 bits with a wrap bit. Invariant: head ≤ commit ≤ tail, taken modulo.
- **Per-entry state:** `addr_valid`, addr, data, op, rob_idx.
- **Allocate.**
  - Occurs when `alloc_valid_i && alloc_ready_o && !flush_i`.
  - Sets entry[tail].addr_valid=0 and increments tail.
  - `alloc_ready_o` = (count < SB_DEPTH) && !flush_i.
- **Fill.**
  - Occurs when `ex_valid_i && !flush_i`.
  - Writes entry[ex_sb_id_i] and sets addr_valid=1.
  - Filling an unallocated id is illegal; an assertion covers it.
- **Commit.**
  - `commit_valid_i` increments `commit`.
  - `commit_valid_i` with commit==tail is illegal (assertion).
- **Drain.**
  - `st_req_valid_o` = (head≠commit) && entry[head].addr_valid.
  - Outputs present entry[head].
  - On `st_req_ready_i` the head increments.
  - Drain continues during flush.
- **Flush.**
  - tail ← commit value after this cycle's commit, i.e. commit applied first.
  - Allocation and fill are ignored that cycle.
  - Committed entries survive.
- **Forwarding:** combinational, against registered entry state only.
  - Older = committed entry, or uncommitted entry with (e.rob − rob_head_i) < (ld_rob − rob_head_i) mod 2^ROB_IDX_WIDTH.
  - Overlap = same 8-byte granule (addr[PLEN-1:3]) and byte masks intersect.
  - Byte mask = size from op, shifted by addr[2:0].
  - `ld_block_o`=1 if any older entry has addr_valid=0.
  - Otherwise select the youngest older overlapping entry:
    - none → hit=0, block=0;
    - exact address match with store size ≥ load size → hit=1, data=entry.data;
    - any other overlap → block=1, hit=0.
  - hit and block are never both 1. `ld_data_o`=0 when hit=0.
- **Size encoding:** B=1, H=2, W=4, D=8 bytes.

## Timing
- Reset values:
  - all pointers 0, all addr_valid 0;
  - `alloc_ready_o`=1, `alloc_sb_id_o`=0, `empty_o`=1;
  - `st_req_valid_o`=0, `ld_hit_o`=0, `ld_block_o`=0, `ld_data_o`=0.
- A fill in cycle N is visible to forwarding and drain in cycle N+1.
- An allocation in cycle N is visible to the query in N+1.
- A commit in cycle N makes the entry drainable in N+1.
- Minimum drain latency is 1 cycle after commit when the D-cache is ready. Throughput is 1 store/cycle.
- Simultaneous events:
  - Allocate and drain in the same cycle when full: allocation is refused (ready is computed from the registered count).
  - Fill to the head entry while draining: the fill wins, being the next-cycle write; the drain only fires if addr_valid was already 1.
- Reset mid-operation discards everything, including committed entries.

## Structure
- Add op→byte-size helper `lsu_size_bytes(lsu_op_e)` to `decode_pkg`, shared with the LSU.
- Sub-module `sb_fwd_select`: combinational youngest-older-overlap priority picker. Inputs are per-entry older/overlap/addr_valid vectors plus the head pointer. Outputs are the selected index and found/unknown flags.

## Test plan
- Alloc 3, fill id0 addr 0x100 SW data 0xDEADBEEF, commit 1, ready=1 → `st_req` 0x100/0xDEADBEEF/SW one cycle later; `empty_o`=1 after the remaining two are flushed.
- Older SW 0x200 data 0x11223344, query LW 0x200 → hit=1, data 0x11223344; query LB 0x202 → block=1.
- Older entry allocated but unfilled, query any address → block=1, hit=0; after the fill to a non-overlapping address → block=0, hit=0.
- Two older SD at 0x300 (data A then B), query LD 0x300 → data B (youngest).
- Fill 16 entries, hold `st_req_ready_i`=0 → `alloc_ready_o`=0; wrap pointers by draining/allocating 40 stores → order preserved.
- 4 entries, commit 2, `flush_i` → tail=commit, 2 committed still drain; `commit_valid_i` with flush in the same cycle preserves 3.

Source files
------------

// File: rtl/config_pkg.sv
// Core configuration record shared by every unit.
// XLEN is the register width, PLEN the physical address width.
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned PLEN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{XLEN: 64, PLEN: 56};

endpackage

// File: rtl/decode_pkg.sv
// Decoded op encodings shared by the decoder, LSU and store buffer.
// lsu_size_bytes gives the access width of any load/store op.
package decode_pkg;

    typedef enum logic [3:0] {
        LSU_LB,
        LSU_LH,
        LSU_LW,
        LSU_LD,
        LSU_LBU,
        LSU_LHU,
        LSU_LWU,
        LSU_SB,
        LSU_SH,
        LSU_SW,
        LSU_SD
    } lsu_op_e;

    function automatic logic [3:0] lsu_size_bytes(lsu_op_e op);
        logic [3:0] sz;
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: sz = 4'd1;
            LSU_LH, LSU_LHU, LSU_SH: sz = 4'd2;
            LSU_LW, LSU_LWU, LSU_SW: sz = 4'd4;
            default:                 sz = 4'd8;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/store_buffer_pkg.sv
// Store buffer helpers: 8-byte granule geometry and byte masks.
// Byte masks are truncated to the granule; accesses are naturally aligned.
package store_buffer_pkg;

    import decode_pkg::*;

    localparam int GranBits = 3;

    function automatic logic [7:0] byte_mask(lsu_op_e op, logic [2:0] off);
        logic [15:0] m;
        case (lsu_size_bytes(op))
            4'd1:    m = 16'h0001;
            4'd2:    m = 16'h0003;
            4'd4:    m = 16'h000F;
            default: m = 16'h00FF;
        endcase
        m = m << off;
        return m[7:0];
    endfunction

endpackage

// File: rtl/sb_fwd_select.sv
// Picks the youngest older overlapping store, walking from head to tail.
// Also flags any older entry whose address is not yet known.
module sb_fwd_select #(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] older_i,
    input  logic [DEPTH-1:0] overlap_i,
    input  logic [DEPTH-1:0] addr_valid_i,
    input  logic [IDX_W-1:0] head_i,
    output logic [IDX_W-1:0] sel_o,
    output logic             found_o,
    output logic             unknown_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        sel_o   = '0;
        found_o = 1'b0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + IDX_W'(k);
            if (older_i[idx] && overlap_i[idx] && addr_valid_i[idx]) begin
                sel_o   = idx;
                found_o = 1'b1;
            end
        end
    end

    assign unknown_o = |(older_i & ~addr_valid_i);

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: allocate at dispatch, fill at execute,
// forward to loads, drain committed stores to the D-cache.
module store_buffer
    import decode_pkg::*;
    import store_buffer_pkg::*;
#(
    parameter config_pkg::cfg_t Cfg = config_pkg::EmptyCfg,
    parameter int ROB_IDX_WIDTH = 6,
    parameter int SB_DEPTH      = 16,
    parameter int SB_IDX_WIDTH  = $clog2(SB_DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [ROB_IDX_WIDTH-1:0] rob_head_i,
    input  logic                     alloc_valid_i,
    output logic                     alloc_ready_o,
    output logic [SB_IDX_WIDTH-1:0]  alloc_sb_id_o,
    input  logic                     ex_valid_i,
    input  logic [SB_IDX_WIDTH-1:0]  ex_sb_id_i,
    input  logic [Cfg.PLEN-1:0]      ex_addr_i,
    input  logic [Cfg.XLEN-1:0]      ex_data_i,
    input  lsu_op_e                  ex_op_i,
    input  logic [ROB_IDX_WIDTH-1:0] ex_rob_idx_i,
    input  logic [Cfg.PLEN-1:0]      ld_addr_i,
    input  lsu_op_e                  ld_op_i,
    input  logic [ROB_IDX_WIDTH-1:0] ld_rob_idx_i,
    output logic                     ld_hit_o,
    output logic                     ld_block_o,
    output logic [Cfg.XLEN-1:0]      ld_data_o,
    input  logic                     commit_valid_i,
    output logic                     st_req_valid_o,
    input  logic                     st_req_ready_i,
    output logic [Cfg.PLEN-1:0]      st_req_addr_o,
    output logic [Cfg.XLEN-1:0]      st_req_data_o,
    output lsu_op_e                  st_req_op_o,
    output logic                     empty_o
);

    localparam int XLEN = int'(Cfg.XLEN);
    localparam int PLEN = int'(Cfg.PLEN);
    localparam int IDX  = SB_IDX_WIDTH;
    localparam int PTR  = SB_IDX_WIDTH + 1;

    logic [PTR-1:0] head_q, commit_q, tail_q;
    logic [PTR-1:0] commit_d, count, ccount;
    logic [IDX-1:0] head_idx, tail_idx, ex_off;

    logic [SB_DEPTH-1:0]      av_q;
    logic [PLEN-1:0]          addr_q [SB_DEPTH];
    logic [XLEN-1:0]          data_q [SB_DEPTH];
    lsu_op_e                  op_q   [SB_DEPTH];
    logic [ROB_IDX_WIDTH-1:0] rob_q  [SB_DEPTH];

    logic do_alloc, do_fill, do_drain, fill_alloc;

    assign head_idx = head_q[IDX-1:0];
    assign tail_idx = tail_q[IDX-1:0];
    assign count    = tail_q - head_q;
    assign ccount   = commit_q - head_q;
    assign commit_d = commit_q + PTR'(commit_valid_i);

    assign alloc_ready_o = (count != PTR'(SB_DEPTH)) && !flush_i;
    assign alloc_sb_id_o = tail_idx;
    assign empty_o       = (head_q == tail_q);

    assign do_alloc = alloc_valid_i && alloc_ready_o;
    assign do_fill  = ex_valid_i && !flush_i;
    assign do_drain = st_req_valid_o && st_req_ready_i;

    assign st_req_valid_o = (head_q != commit_q) && av_q[head_idx];
    assign st_req_addr_o  = addr_q[head_idx];
    assign st_req_data_o  = data_q[head_idx];
    assign st_req_op_o    = op_q[head_idx];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= '0;
            av_q     <= '0;
        end else begin
            if (do_drain) head_q <= head_q + PTR'(1);
            commit_q <= commit_d;
            if (flush_i) begin
                tail_q <= commit_d;
            end else if (do_alloc) begin
                tail_q <= tail_q + PTR'(1);
            end
            if (do_alloc) av_q[tail_idx] <= 1'b0;
            if (do_fill) av_q[ex_sb_id_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_fill) begin
            addr_q[ex_sb_id_i] <= ex_addr_i;
            data_q[ex_sb_id_i] <= ex_data_i;
            op_q[ex_sb_id_i]   <= ex_op_i;
            rob_q[ex_sb_id_i]  <= ex_rob_idx_i;
        end
    end

    logic [SB_DEPTH-1:0]      older, overlap;
    logic [7:0]               ld_mask;
    logic [ROB_IDX_WIDTH-1:0] ld_age;

    assign ld_mask = byte_mask(ld_op_i, ld_addr_i[GranBits-1:0]);
    assign ld_age  = ld_rob_idx_i - rob_head_i;

    for (genvar i = 0; i < SB_DEPTH; i++) begin : g_ent
        localparam logic [IDX-1:0] Idx = IDX'(i);
        logic [IDX-1:0]           off;
        logic [ROB_IDX_WIDTH-1:0] age;
        logic                     in_win, committed;
        assign off       = Idx - head_idx;
        assign in_win    = {1'b0, off} < count;
        assign committed = {1'b0, off} < ccount;
        assign age       = rob_q[i] - rob_head_i;
        // an unfilled entry has no trusted ROB tag yet, so assume it is older
        assign older[i]   = in_win && (committed || !av_q[i] || age < ld_age);
        assign overlap[i] =
            (addr_q[i][PLEN-1:GranBits] == ld_addr_i[PLEN-1:GranBits]) &&
            |(byte_mask(op_q[i], addr_q[i][GranBits-1:0]) & ld_mask);
    end

    logic [IDX-1:0] sel;
    logic           found, unknown, exact;

    sb_fwd_select #(
        .DEPTH(SB_DEPTH),
        .IDX_W(IDX)
    ) u_sel (
        .older_i     (older),
        .overlap_i   (overlap),
        .addr_valid_i(av_q),
        .head_i      (head_idx),
        .sel_o       (sel),
        .found_o     (found),
        .unknown_o   (unknown)
    );

    assign exact = (addr_q[sel] == ld_addr_i) &&
                   (lsu_size_bytes(op_q[sel]) >= lsu_size_bytes(ld_op_i));

    assign ld_hit_o   = found && !unknown && exact;
    assign ld_block_o = unknown || (found && !exact);
    assign ld_data_o  = ld_hit_o ? data_q[sel] : '0;

    assign ex_off     = ex_sb_id_i - head_idx;
    assign fill_alloc = {1'b0, ex_off} < count;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(do_fill && !fill_alloc));
            assert (!(commit_valid_i && commit_q == tail_q));
        end
    end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed checks of store_buffer against a
// queue-based reference model of program-order stores.
module tb_store_buffer;

    import decode_pkg::*;

    localparam int XLEN  = 64;
    localparam int PLEN  = 56;
    localparam int RW    = 6;
    localparam int DEPTH = 16;
    localparam int IW    = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic [RW-1:0]   rob_head_i = '0;
    logic            alloc_valid_i = 1'b0;
    logic            alloc_ready_o;
    logic [IW-1:0]   alloc_sb_id_o;
    logic            ex_valid_i = 1'b0;
    logic [IW-1:0]   ex_sb_id_i = '0;
    logic [PLEN-1:0] ex_addr_i = '0;
    logic [XLEN-1:0] ex_data_i = '0;
    lsu_op_e         ex_op_i = LSU_SB;
    logic [RW-1:0]   ex_rob_idx_i = '0;
    logic [PLEN-1:0] ld_addr_i = '0;
    lsu_op_e         ld_op_i = LSU_LB;
    logic [RW-1:0]   ld_rob_idx_i = '0;
    logic            ld_hit_o;
    logic            ld_block_o;
    logic [XLEN-1:0] ld_data_o;
    logic            commit_valid_i = 1'b0;
    logic            st_req_valid_o;
    logic            st_req_ready_i = 1'b0;
    logic [PLEN-1:0] st_req_addr_o;
    logic [XLEN-1:0] st_req_data_o;
    lsu_op_e         st_req_op_o;
    logic            empty_o;

    store_buffer #(
        .Cfg          (config_pkg::EmptyCfg),
        .ROB_IDX_WIDTH(RW),
        .SB_DEPTH     (DEPTH),
        .SB_IDX_WIDTH (IW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .rob_head_i    (rob_head_i),
        .alloc_valid_i (alloc_valid_i),
        .alloc_ready_o (alloc_ready_o),
        .alloc_sb_id_o (alloc_sb_id_o),
        .ex_valid_i    (ex_valid_i),
        .ex_sb_id_i    (ex_sb_id_i),
        .ex_addr_i     (ex_addr_i),
        .ex_data_i     (ex_data_i),
        .ex_op_i       (ex_op_i),
        .ex_rob_idx_i  (ex_rob_idx_i),
        .ld_addr_i     (ld_addr_i),
        .ld_op_i       (ld_op_i),
        .ld_rob_idx_i  (ld_rob_idx_i),
        .ld_hit_o      (ld_hit_o),
        .ld_block_o    (ld_block_o),
        .ld_data_o     (ld_data_o),
        .commit_valid_i(commit_valid_i),
        .st_req_valid_o(st_req_valid_o),
        .st_req_ready_i(st_req_ready_i),
        .st_req_addr_o (st_req_addr_o),
        .st_req_data_o (st_req_data_o),
        .st_req_op_o   (st_req_op_o),
        .empty_o       (empty_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int              id;
        bit              filled;
        logic [PLEN-1:0] addr;
        logic [XLEN-1:0] data;
        lsu_op_e         op;
        logic [RW-1:0]   rob;
    } ent_t;

    ent_t          q[$];
    int            ncom = 0;
    int            mtail = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_drained = 0;
    int            ld_age = 40;
    logic [RW-1:0] rob_next = '0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int size_of(lsu_op_e op);
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: return 1;
            LSU_LH, LSU_LHU, LSU_SH: return 2;
            LSU_LW, LSU_LWU, LSU_SW: return 4;
            default:                 return 8;
        endcase
    endfunction

    function automatic void ref_fwd(output bit hit, output bit blk,
                                    output logic [63:0] data);
        bit            unk;
        int            fi, la, ls, sa, ss;
        logic [RW-1:0] lage, eage;
        unk = 0; fi = -1; hit = 0; blk = 0; data = '0;
        la = int'(ld_addr_i[2:0]);
        ls = size_of(ld_op_i);
        lage = ld_rob_idx_i - rob_head_i;
        for (int i = 0; i < q.size(); i++) begin
            eage = q[i].rob - rob_head_i;
            if (!(i < ncom || !q[i].filled || eage < lage)) continue;
            if (!q[i].filled) begin
                unk = 1;
                continue;
            end
            sa = int'(q[i].addr[2:0]);
            ss = size_of(q[i].op);
            if ((q[i].addr >> 3) == (ld_addr_i >> 3) && sa < la + ls && la < sa + ss)
                fi = i;
        end
        if (unk) begin
            blk = 1;
        end else if (fi >= 0) begin
            if (q[fi].addr == ld_addr_i && size_of(q[fi].op) >= ls) begin
                hit = 1;
                data = q[fi].data;
            end else begin
                blk = 1;
            end
        end
    endfunction

    task automatic set_rob();
        rob_head_i = (ncom < q.size()) ? q[ncom].rob : rob_next;
        ld_rob_idx_i = rob_head_i + RW'(ld_age);
    endtask

    // Checks every output against the model, then advances one clock.
    task automatic cycle();
        bit          ev, eh, eb, drained, alloc_ok;
        logic [63:0] ed;
        set_rob();
        #1;
        ev = (ncom > 0) && q[0].filled;
        check("alloc_ready", 64'(alloc_ready_o), 64'(q.size() < DEPTH && !flush_i));
        check("alloc_id", 64'(alloc_sb_id_o), 64'(mtail % DEPTH));
        check("empty", 64'(empty_o), 64'(q.size() == 0));
        check("st_valid", 64'(st_req_valid_o), 64'(ev));
        if (ev) begin
            check("st_addr", 64'(st_req_addr_o), 64'(q[0].addr));
            check("st_data", st_req_data_o, q[0].data);
            check("st_op", 64'(st_req_op_o), 64'(q[0].op));
        end
        ref_fwd(eh, eb, ed);
        check("ld_hit", 64'(ld_hit_o), 64'(eh));
        check("ld_block", 64'(ld_block_o), 64'(eb));
        check("ld_data", ld_data_o, ed);
        alloc_ok = alloc_valid_i && !flush_i && q.size() < DEPTH;
        drained = ev && st_req_ready_i;
        if (ex_valid_i && !flush_i) begin
            foreach (q[i]) begin
                if (q[i].id == int'(ex_sb_id_i)) begin
                    q[i].filled = 1;
                    q[i].addr = ex_addr_i;
                    q[i].data = ex_data_i;
                    q[i].op = ex_op_i;
                end
            end
        end
        if (drained) begin
            void'(q.pop_front());
            ncom--;
            n_drained++;
        end
        if (commit_valid_i) ncom++;
        if (flush_i) begin
            while (q.size() > ncom) begin
                void'(q.pop_back());
                mtail--;
            end
        end else if (alloc_ok) begin
            q.push_back('{id: mtail % DEPTH, filled: 0, addr: '0, data: '0,
                          op: LSU_SB, rob: rob_next});
            mtail++;
            rob_next++;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle_in();
        alloc_valid_i = 0;
        ex_valid_i = 0;
        commit_valid_i = 0;
        flush_i = 0;
    endtask

    function automatic logic [RW-1:0] rob_of(int id);
        foreach (q[i]) if (q[i].id == id) return q[i].rob;
        return '0;
    endfunction

    task automatic t_alloc(int n);
        repeat (n) begin
            alloc_valid_i = 1;
            cycle();
        end
        alloc_valid_i = 0;
    endtask

    task automatic t_fill(int id, logic [PLEN-1:0] a, lsu_op_e op, logic [XLEN-1:0] d);
        ex_valid_i = 1;
        ex_sb_id_i = IW'(id % DEPTH);
        ex_addr_i = a;
        ex_op_i = op;
        ex_data_i = d;
        ex_rob_idx_i = rob_of(id % DEPTH);
        cycle();
        ex_valid_i = 0;
    endtask

    task automatic t_commit(int n);
        repeat (n) begin
            commit_valid_i = 1;
            cycle();
        end
        commit_valid_i = 0;
    endtask

    task automatic t_flush();
        flush_i = 1;
        cycle();
        flush_i = 0;
    endtask

    task automatic query(string tag, logic [PLEN-1:0] a, lsu_op_e op,
                         bit hit, bit blk, logic [63:0] data);
        ld_addr_i = a;
        ld_op_i = op;
        set_rob();
        #1;
        check({tag, "_hit"}, 64'(ld_hit_o), 64'(hit));
        check({tag, "_block"}, 64'(ld_block_o), 64'(blk));
        check({tag, "_data"}, ld_data_o, data);
        cycle();
    endtask

    task automatic fill_oldest_unfilled();
        ex_valid_i = 0;
        foreach (q[i]) begin
            if (!q[i].filled && !ex_valid_i) begin
                ex_valid_i = 1;
                ex_sb_id_i = IW'(q[i].id);
                ex_rob_idx_i = q[i].rob;
                ex_op_i = LSU_SD;
                ex_addr_i = PLEN'('h1000 + 8 * (mtail % 64));
                ex_data_i = {$urandom, $urandom};
            end
        end
    endtask

    // Drops speculative entries and drains the rest, bounded in cycles.
    task automatic drain_all(string tag);
        t_flush();
        st_req_ready_i = 1;
        for (int c = 0; c < 100 && q.size() > 0; c++) begin
            fill_oldest_unfilled();
            cycle();
        end
        idle_in();
        #1;
        check(tag, 64'(empty_o), 64'd1);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        idle_in();
        rst_ni = 0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1;
        q.delete();
        ncom = 0;
        mtail = 0;
        #1;
        check("rst_empty", 64'(empty_o), 64'd1);
        check("rst_ready", 64'(alloc_ready_o), 64'd1);
        check("rst_id", 64'(alloc_sb_id_o), 64'd0);
        check("rst_st_valid", 64'(st_req_valid_o), 64'd0);
        check("rst_hit", 64'(ld_hit_o), 64'd0);
        check("rst_block", 64'(ld_block_o), 64'd0);
        check("rst_data", ld_data_o, 64'd0);
        @(negedge clk_i);
    endtask

    function automatic logic [PLEN-1:0] rand_addr(lsu_op_e op);
        int off;
        off = $urandom_range(0, 7) & ~(size_of(op) - 1);
        return PLEN'('h100 + 8 * $urandom_range(0, 2) + off);
    endfunction

    initial begin
        int base, d0, k;
        int uf[$];
        @(negedge clk_i);
        do_reset();
        cycle();

        st_req_ready_i = 1;
        t_alloc(3);
        t_fill(0, 'h100, LSU_SW, 'hDEADBEEF);
        t_commit(1);
        #1;
        check("tp1_st_valid", 64'(st_req_valid_o), 64'd1);
        check("tp1_st_addr", 64'(st_req_addr_o), 64'h100);
        check("tp1_st_data", st_req_data_o, 64'hDEADBEEF);
        check("tp1_st_op", 64'(st_req_op_o), 64'(LSU_SW));
        cycle();
        t_flush();
        #1;
        check("tp1_empty", 64'(empty_o), 64'd1);

        st_req_ready_i = 0;
        base = mtail;
        t_alloc(1);
        t_fill(base, 'h200, LSU_SW, 'h11223344);
        query("tp2_lw", 'h200, LSU_LW, 1, 0, 'h11223344);
        query("tp2_lb", 'h202, LSU_LB, 0, 1, 0);
        t_flush();

        base = mtail;
        t_alloc(1);
        query("tp3_unfilled", 'h500, LSU_LD, 0, 1, 0);
        t_fill(base, 'h600, LSU_SD, 'h1);
        query("tp3_disjoint", 'h500, LSU_LD, 0, 0, 0);
        t_flush();

        base = mtail;
        t_alloc(2);
        t_fill(base, 'h300, LSU_SD, 'hAAAA_0000_AAAA_0000);
        t_fill(base + 1, 'h300, LSU_SD, 'hBBBB_1111_BBBB_1111);
        query("tp4_young", 'h300, LSU_LD, 1, 0, 'hBBBB_1111_BBBB_1111);
        t_flush();

        st_req_ready_i = 0;
        t_alloc(16);
        #1;
        check("tp5_full", 64'(alloc_ready_o), 64'd0);
        d0 = n_drained;
        st_req_ready_i = 1;
        for (int c = 0; c < 80; c++) begin
            alloc_valid_i = 1;
            fill_oldest_unfilled();
            commit_valid_i = (ncom < q.size());
            cycle();
            idle_in();
        end
        check("tp5_drained", 64'((n_drained - d0) >= 40), 64'd1);
        drain_all("tp5_empty");

        st_req_ready_i = 0;
        base = mtail;
        t_alloc(4);
        t_fill(base, 'h700, LSU_SW, 'h7);
        t_fill(base + 1, 'h708, LSU_SW, 'h8);
        t_commit(2);
        t_flush();
        #1;
        check("tp6_tail", 64'(alloc_sb_id_o), 64'((base + 2) % DEPTH));
        check("tp6_not_empty", 64'(empty_o), 64'd0);
        st_req_ready_i = 1;
        repeat (3) cycle();
        #1;
        check("tp6_drained", 64'(empty_o), 64'd1);

        st_req_ready_i = 0;
        base = mtail;
        t_alloc(4);
        for (int i = 0; i < 4; i++) t_fill(base + i, PLEN'('h800 + 8 * i), LSU_SD, 64'(i));
        t_commit(2);
        commit_valid_i = 1;
        flush_i = 1;
        cycle();
        idle_in();
        #1;
        check("tp6_keep3", 64'(alloc_sb_id_o), 64'((base + 3) % DEPTH));
        drain_all("tp6_empty");

        for (int c = 0; c < 3000; c++) begin
            idle_in();
            alloc_valid_i = 1'($urandom_range(0, 1));
            flush_i = ($urandom_range(0, 49) == 0);
            commit_valid_i = (ncom < q.size()) && ($urandom_range(0, 2) == 0);
            st_req_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                uf.delete();
                foreach (q[i]) if (!q[i].filled) uf.push_back(i);
                if (uf.size() > 0) begin
                    k = uf[$urandom_range(0, uf.size() - 1)];
                    ex_valid_i = 1;
                    ex_sb_id_i = IW'(q[k].id);
                    ex_rob_idx_i = q[k].rob;
                    ex_op_i = lsu_op_e'(7 + $urandom_range(0, 3));
                    ex_addr_i = rand_addr(ex_op_i);
                    ex_data_i = {$urandom, $urandom};
                end
            end
            ld_op_i = lsu_op_e'($urandom_range(0, 6));
            ld_addr_i = rand_addr(ld_op_i);
            ld_age = $urandom_range(0, 20);
            cycle();
        end
        idle_in();
        ld_age = 40;

        st_req_ready_i = 0;
        t_alloc(5);
        t_commit(2);
        do_reset();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
